sha512_msg_sched: RTL
=====================

Name: sha512_msg_sched

Overview:
SHA-512 message schedule stage, directly downstream of the padding stage. Consumes the padded 64-bit word stream, 16 words per 1024-bit chunk. Emits the 80 schedule words W[0..79] per chunk, each tagged with its round index, to the compression round logic. Buffers the last 16 words in a sliding window and computes W[16..79] on the fly.

Parameters:
NUM_ROUND, 80, schedule words emitted per chunk (fixed by SHA-512; not overridable in practice)
BLK_WORDS, 16, input words per chunk

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
sha_en  input  1  engine enable; low forces the idle/flush behaviour
hash_start  input  1  one-cycle pulse; aborts any chunk in progress and restarts at round 0
in_valid  input  1  padded word valid (from the pad stage's shaf_rvalid)
in_data  input  64  padded word (shaf_rdata)
in_ready  output  1  word accepted (drives the pad stage's shaf_rready)
w_valid  output  1  schedule word valid to the round logic
w_data  output  64  W[t]
w_round  output  7  t, 0..79
w_ready  input  1  round logic accepts W[t]
chunk_done  output  1  one-cycle pulse when W[79] is accepted by the round logic
busy  output  1  high while in StLoad with round>0, or in StExpand

Behaviour:
- Reset (rst_i high at a clock edge), outputs after that edge:
  - in_ready=0, w_valid=0, w_data=0, w_round=0, chunk_done=0, busy=0.
  - State=StIdle; window cleared to zero; round counter t=0.
- Outputs are registered through a one-entry output register.
  - adv = !w_valid || w_ready. The register loads only when adv=1.
  - Otherwise w_data, w_round and w_valid hold stable (no change while stalled).
- States:
  - StIdle: in_ready=0. sha_en && hash_start -> StLoad, t=0.
  - StLoad (t<16): in_ready=adv. On in_valid && in_ready:
    - w_data<=in_data, w_round<=t, w_valid<=1;
    - in_data shifts into window slot 15 (oldest word drops from slot 0);
    - t<=t+1;
    - if t==15, go to StExpand.
    - Latency: in_data accepted at edge N appears on w_data after edge N; zero bubbles at full throughput.
  - StExpand (16<=t<=79): in_ready=0. On adv=1:
    - w_data <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^64 (win[15] is newest);
    - the result shifts into the window; w_round<=t; w_valid<=1; t<=t+1.
    - When t==79 is loaded, go to StLoad with t=0 (next chunk); the window is not cleared.
- Sigma functions:
  - sigma0(x) = ROTR1(x) ^ ROTR8(x) ^ SHR7(x)
  - sigma1(x) = ROTR19(x) ^ ROTR61(x) ^ SHR6(x)
  - All arithmetic is 64-bit unsigned, carries discarded.
- chunk_done: pulses the cycle after w_valid && w_ready with w_round==79.
- w_valid clears when the round logic accepts and no new word is loaded that cycle.
- Round counter: 7-bit; t never exceeds 79; returns to 0 on chunk wrap.
- hash_start mid-chunk (sha_en high), at the next edge:
  - t=0, state StLoad, w_valid=0;
  - any pending word is dropped; the window is not required to clear.
  - hash_start takes priority over the same-cycle input handshake; in_ready is 0 that cycle.
- sha_en low: at the next edge, state StIdle, w_valid=0, t=0. in_ready=0 while sha_en is low.
- rst_i mid-chunk: same as power-up reset; any in-flight word is lost.
- Back-to-back chunks: the first word of chunk n+1 can be accepted in the cycle after W[79] of chunk n is loaded.
- in_valid outside StLoad is ignored; no words are consumed.

Test Plan:
- "abc" block: hash_start, then feed 16 words with W0=0x6162638000000000, W1..W14=0, W15=0x18, w_ready=1 -> w_round 0..79 contiguous, one per cycle after the first, with W16=0x6162638000000000 and W17=0x00030000000000C0. Full W[0..79] matches the FIPS 180-4 reference model; one chunk_done pulse.
- Backpressure: w_ready toggles randomly (50%) over the same block -> identical W sequence; w_data/w_round stable while w_valid && !w_ready; in_ready=0 whenever output is stalled.
- Two chunks back-to-back (the padded 896-bit "abcdbcdefgh..." message) -> 160 words, round wraps 79->0, two chunk_done pulses, all W match the reference model.
- hash_start asserted at round 40 -> next edge w_valid=0, t=0; a fresh "abc" block then yields the correct W[0..79].
- in_valid gaps (in_valid low 3 cycles between words 5 and 6) -> w_valid drops during the gap, no duplicate or skipped rounds.
- rst_i at round 20, and sha_en deassertion at round 10 -> all outputs reach their reset values at the next edge; in_ready stays 0 until the next hash_start.

Source files
------------

// File: rtl/sha512_msg_sched.sv
// SHA-512 message schedule: passes W[0..15] through from the pad stage and
// expands W[16..79] from a 16-word sliding window, one word per accepted slot.
module sha512_msg_sched #(
  parameter int unsigned NUM_ROUND = 80,
  parameter int unsigned BLK_WORDS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sha_en,
  input  logic        hash_start,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        w_valid,
  output logic [63:0] w_data,
  output logic [6:0]  w_round,
  input  logic        w_ready,
  output logic        chunk_done,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

  state_e      state_q, state_d;
  logic [6:0]  t_q, t_d;
  logic [63:0] win_q [BLK_WORDS];
  logic [63:0] win_d [BLK_WORDS];
  logic [63:0] w_data_q, w_data_d;
  logic [6:0]  w_round_q, w_round_d;
  logic        w_valid_q, w_valid_d;
  logic        chunk_done_q, chunk_done_d;

  logic        adv;
  logic        shift_en;
  logic [63:0] shift_word;
  logic [63:0] w_new;

  function automatic logic [63:0] sigma0(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sigma1(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // win_q[15] is W[t-1], so taps 14/9/1/0 are W[t-2], W[t-7], W[t-15], W[t-16].
  assign w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  assign adv      = !w_valid_q || w_ready;
  assign in_ready = (state_q == StLoad) && adv && sha_en && !hash_start;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    w_data_d     = w_data_q;
    w_round_d    = w_round_q;
    w_valid_d    = w_valid_q;
    chunk_done_d = w_valid_q && w_ready && (w_round_q == 7'(NUM_ROUND - 1));
    shift_en     = 1'b0;
    shift_word   = in_data;

    if (!sha_en) begin
      state_d      = StIdle;
      t_d          = '0;
      w_valid_d    = 1'b0;
      w_data_d     = '0;
      w_round_d    = '0;
      chunk_done_d = 1'b0;
    end else if (hash_start) begin
      state_d   = StLoad;
      t_d       = '0;
      w_valid_d = 1'b0;
    end else if (adv) begin
      w_valid_d = 1'b0;
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            shift_en   = 1'b1;
            shift_word = in_data;
            w_data_d   = in_data;
            w_round_d  = t_q;
            w_valid_d  = 1'b1;
            t_d        = t_q + 7'd1;
            if (t_q == 7'(BLK_WORDS - 1)) state_d = StExpand;
          end
        end
        StExpand: begin
          shift_en   = 1'b1;
          shift_word = w_new;
          w_data_d   = w_new;
          w_round_d  = t_q;
          w_valid_d  = 1'b1;
          if (t_q == 7'(NUM_ROUND - 1)) begin
            state_d = StLoad;
            t_d     = '0;
          end else begin
            t_d = t_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      for (int unsigned i = 0; i < BLK_WORDS - 1; i++) win_d[i] = win_q[i+1];
      win_d[BLK_WORDS-1] = shift_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      t_q          <= '0;
      w_data_q     <= '0;
      w_round_q    <= '0;
      w_valid_q    <= 1'b0;
      chunk_done_q <= 1'b0;
      for (int unsigned i = 0; i < BLK_WORDS; i++) win_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      w_data_q     <= w_data_d;
      w_round_q    <= w_round_d;
      w_valid_q    <= w_valid_d;
      chunk_done_q <= chunk_done_d;
      win_q        <= win_d;
    end
  end

  assign w_valid    = w_valid_q;
  assign w_data     = w_data_q;
  assign w_round    = w_round_q;
  assign chunk_done = chunk_done_q;
  assign busy       = ((state_q == StLoad) && (t_q != '0)) || (state_q == StExpand);

endmodule
